// File: rtl/vpg_pkg.sv
// Shared types and helpers for the video pattern generator: pattern mode
// encoding, the colour-bar lookup table and the timing-total helper.
package vpg_pkg;

  typedef enum logic [2:0] {
    MODE_GRID    = 3'd0,
    MODE_BARS    = 3'd1,
    MODE_SOLID   = 3'd2,
    MODE_RAMP    = 3'd3,
    MODE_CHECKER = 3'd4
  } mode_e;

  // Bar colours as {R,G,B} on/off flags; entry 0 sits in the LSBs.
  // Order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                       3'b010, 3'b011, 3'b110, 3'b111};

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    return BAR_TABLE[5'(idx) * 5'd3 +: 3];
  endfunction

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Video output bus of the pattern generator: position, timing flags and RGB.
// The generator drives it through the master modport, sinks use slave.
interface video_pattern_gen_if #(
  parameter int CNT_W   = 12,
  parameter int COLOR_W = 8
);
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               de;
  logic               hsync;
  logic               vsync;
  logic               frame_start;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  modport master (output x, y, de, hsync, vsync, frame_start, red, green, blue);
  modport slave  (input  x, y, de, hsync, vsync, frame_start, red, green, blue);
endinterface

// File: rtl/vpg_timing.sv
// Raster timing: h/v counters plus registered position, DE, syncs and the
// frame-start pulse. Counter state is also exported so the parent can build
// the pixel colour for the same cycle and register it with equal latency.
module vpg_timing
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CNT_W    = 12
) (
  input  logic             pixclk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_h,
  output logic [CNT_W-1:0] o_v,
  output logic             o_active,
  output logic             o_origin,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_frame_start
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON  = (HS_POL != 0);
  localparam logic             VS_ON  = (VS_POL != 0);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             w_hs;
  logic             w_vs;

  assign o_h      = r_h;
  assign o_v      = r_v;
  assign o_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_origin = (r_h == '0) && (r_v == '0);
  assign w_hs     = (r_h >= HS_BEG) && (r_h < HS_END);
  // vsync depends on v only, and v only moves on the h wrap, so it flips at h=0
  assign w_vs     = (r_v >= VS_BEG) && (r_v < VS_END);

  // Raster counters: h wraps at end of line and carries into v
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_en) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + ONE;
      end else begin
        r_h <= r_h + ONE;
      end
    end
  end

  // Timing outputs, one cycle behind the counters; paused cycles blank DE and
  // frame_start while position and syncs keep their last value
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      o_x           <= '0;
      o_y           <= '0;
      o_de          <= 1'b0;
      o_hsync       <= ~HS_ON;
      o_vsync       <= ~VS_ON;
      o_frame_start <= 1'b0;
    end else if (i_en) begin
      o_x           <= r_h;
      o_y           <= r_v;
      o_de          <= o_active;
      o_hsync       <= w_hs ? HS_ON : ~HS_ON;
      o_vsync       <= w_vs ? VS_ON : ~VS_ON;
      o_frame_start <= o_origin;
    end else begin
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source. Optional build macro VPG_SCROLL_EN
// adds a 16-bit frame counter (output frame_cnt) that scrolls the bars, ramp
// and checker patterns one pixel per frame.
// The grid pattern needs CNT_W >= 8; COLOR_W must not exceed CNT_W.
module video_pattern_gen
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 12,
  parameter int CHK_LOG2 = 5
) (
  input  logic                 pixclk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  video_pattern_gen_if.master  vid,
  output logic [2:0]           mode_active
`ifdef VPG_SCROLL_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int               H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int               BW      = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(BW - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0]   w_h;
  logic [CNT_W-1:0]   w_v;
  logic               w_active;
  logic               w_origin;
  logic               w_start;
  logic [2:0]         w_mode_eff;
  logic [CNT_W-1:0]   w_xs;
  logic [2:0]         w_bar_idx;
  logic [2:0]         w_bar_rgb;
  logic [7:0]         w_x8;
  logic [7:0]         w_y8;
  logic               w_white;
  logic               w_area;
  logic               w_rmask;
  logic [7:0]         w_gr8;
  logic [7:0]         w_gg8;
  logic [7:0]         w_gb8;
  logic [COLOR_W-1:0] w_gr;
  logic [COLOR_W-1:0] w_gg;
  logic [COLOR_W-1:0] w_gb;
  logic               w_chk;
  logic [COLOR_W-1:0] w_r;
  logic [COLOR_W-1:0] w_g;
  logic [COLOR_W-1:0] w_b;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;

  vpg_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CNT_W(CNT_W)
  ) u_timing (
    .pixclk        (pixclk),
    .rst           (rst),
    .i_en          (en),
    .o_h           (w_h),
    .o_v           (w_v),
    .o_active      (w_active),
    .o_origin      (w_origin),
    .o_x           (vid.x),
    .o_y           (vid.y),
    .o_de          (vid.de),
    .o_hsync       (vid.hsync),
    .o_vsync       (vid.vsync),
    .o_frame_start (vid.frame_start)
  );

  // The first pixel of a frame already uses the newly requested mode
  assign w_start    = en && w_origin;
  assign w_mode_eff = w_start ? mode : mode_active;

  // Mode latch: only a frame start may change the displayed pattern
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      mode_active <= 3'd0;
    end else if (w_start) begin
      mode_active <= mode;
    end else begin
      mode_active <= mode_active;
    end
  end

`ifdef VPG_SCROLL_EN
  logic [15:0] r_frame_next;
  logic [15:0] r_frame_cnt;
  logic [15:0] w_off;

  // r_frame_next counts frame starts; r_frame_cnt is the index of the frame on screen
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_frame_next <= 16'd0;
      r_frame_cnt  <= 16'd0;
    end else if (w_start) begin
      r_frame_cnt  <= r_frame_next;
      r_frame_next <= r_frame_next + 16'd1;
    end else begin
      r_frame_cnt  <= r_frame_cnt;
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign w_off     = w_start ? r_frame_next : r_frame_cnt;
  assign w_xs      = w_h + CNT_W'(w_off);

  // Scrolled bars do not start at a line boundary, so the index comes from
  // comparing the shifted position against the fixed bar edges
  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      w_bar_idx = (w_xs >= CNT_W'(k * BW)) ? 3'(k) : w_bar_idx;
    end
  end
`else
  logic [2:0]       r_bar_idx;
  logic [CNT_W-1:0] r_bar_cnt;

  assign w_xs      = w_h;
  assign w_bar_idx = r_bar_idx;

  // Bar sub-counter tracks h: restarts each line, steps the index every BW pixels, saturates at 7
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_bar_idx <= 3'd0;
      r_bar_cnt <= '0;
    end else if (en) begin
      if (w_h == H_LAST) begin
        r_bar_idx <= 3'd0;
        r_bar_cnt <= '0;
      end else if (r_bar_cnt == BW_LAST) begin
        r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
        r_bar_cnt <= '0;
      end else begin
        r_bar_cnt <= r_bar_cnt + ONE;
      end
    end
  end
`endif

  assign w_bar_rgb = bar_color(w_bar_idx);
  assign w_chk     = w_xs[CHK_LOG2] ^ w_v[CHK_LOG2];

  // Legacy 8-bit grid, then MSB-aligned onto COLOR_W
  assign w_x8    = 8'(w_h);
  assign w_y8    = 8'(w_v);
  assign w_white = (w_x8 == w_y8);
  assign w_area  = (w_x8[7:5] == 3'd2) && (w_y8[7:5] == 3'd2);
  assign w_rmask = (w_y8[4:3] == ~w_x8[4:3]);
  assign w_gr8   = ({w_x8[5:0] & {6{w_rmask}}, 2'b00} | {8{w_white}}) & ~{8{w_area}};
  assign w_gg8   = ((w_x8 & {8{w_y8[6]}}) | {8{w_white}}) & ~{8{w_area}};
  assign w_gb8   = w_y8 | {8{w_white}} | {8{w_area}};
  assign w_gr    = COLOR_W'({w_gr8, 4'h0} >> (12 - COLOR_W));
  assign w_gg    = COLOR_W'({w_gg8, 4'h0} >> (12 - COLOR_W));
  assign w_gb    = COLOR_W'({w_gb8, 4'h0} >> (12 - COLOR_W));

  // Pattern mux for the pixel at the current counter position
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (w_mode_eff)
      MODE_GRID: begin
        w_r = w_gr;
        w_g = w_gg;
        w_b = w_gb;
      end
      MODE_BARS: begin
        w_r = {COLOR_W{w_bar_rgb[2]}};
        w_g = {COLOR_W{w_bar_rgb[1]}};
        w_b = {COLOR_W{w_bar_rgb[0]}};
      end
      MODE_SOLID: begin
        w_r = solid_rgb[3*COLOR_W-1 -: COLOR_W];
        w_g = solid_rgb[2*COLOR_W-1 -: COLOR_W];
        w_b = solid_rgb[COLOR_W-1 -: COLOR_W];
      end
      MODE_RAMP: begin
        w_r = COLOR_W'(w_xs);
        w_g = COLOR_W'(w_xs);
        w_b = COLOR_W'(w_xs);
      end
      MODE_CHECKER: begin
        w_r = {COLOR_W{w_chk}};
        w_g = {COLOR_W{w_chk}};
        w_b = {COLOR_W{w_chk}};
      end
      default: begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
      end
    endcase
  end

  // Colour output register, blanked outside active video and while paused
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (en && w_active) begin
      r_red   <= w_r;
      r_green <= w_g;
      r_blue  <= w_b;
    end else begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end
  end

  assign vid.red   = r_red;
  assign vid.green = r_green;
  assign vid.blue  = r_blue;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a reduced raster (120x10 total,
// 100x6 active) so several whole frames fit in a short run.
module tb_video_pattern_gen;

  localparam int H_ACTIVE = 100;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 8;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int HS_POL   = 1;
  localparam int VS_POL   = 0;
  localparam int COLOR_W  = 8;
  localparam int CNT_W    = 12;
  localparam int CHK_LOG2 = 2;
  localparam int H_TOTAL  = 120;
  localparam int V_TOTAL  = 10;

  logic        pixclk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic [2:0]  mode_active;
  logic [23:0] rgb;
`ifdef VPG_SCROLL_EN
  logic [15:0] frame_cnt;
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  video_pattern_gen_if #(.CNT_W(CNT_W), .COLOR_W(COLOR_W)) vid ();

  video_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_W(COLOR_W), .CNT_W(CNT_W),
    .CHK_LOG2(CHK_LOG2)
  ) dut (
    .pixclk      (pixclk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .vid         (vid),
    .mode_active (mode_active)
`ifdef VPG_SCROLL_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 pixclk = ~pixclk;

  assign rgb = {vid.red, vid.green, vid.blue};

  int total = 0;
  int bad = 0;
  // raster model: counter state, displayed pixel, frame index
  int mc_h = 0;
  int mc_v = 0;
  int disp_h = -1;
  int disp_v = -1;
  int n_starts = 0;
  int cur_frame = 0;
  int n_steps = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock and sample at the falling edge; update the model if that edge was enabled
  task automatic step();
    @(negedge pixclk);
    n_steps++;
    if (en && !rst) begin
      disp_h = mc_h;
      disp_v = mc_v;
      if (mc_h == 0 && mc_v == 0) begin
        cur_frame = n_starts;
        n_starts++;
      end
      if (mc_h == H_TOTAL - 1) begin
        mc_h = 0;
        mc_v = (mc_v == V_TOTAL - 1) ? 0 : mc_v + 1;
      end else begin
        mc_h++;
      end
    end
  endtask

  // run to the given displayed pixel (bounded) and confirm the DUT position
  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(disp_h == h && disp_v == v) && n < 3000);
    check_val($sformatf("pos_%0d_%0d", h, v), {8'd0, vid.x, vid.y}, {8'd0, 12'(h), 12'(v)});
  endtask

  function automatic logic [23:0] grey(input int x);
    int off;
    logic [7:0] g;
    off = SCROLL ? cur_frame : 0;
    g = 8'(x + off);
    return {g, g, g};
  endfunction

  function automatic logic [23:0] chk(input int x, input int y);
    int off;
    off = SCROLL ? cur_frame : 0;
    return (((((x + off) >> 2) ^ (y >> 2)) & 1) != 0) ? 24'hffffff : 24'h000000;
  endfunction

  int          bx[6] = '{11, 12, 24, 83, 84, 99};
  logic [23:0] be[6] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h0000ff, 24'h000000, 24'h000000};
  int          hx[4] = '{103, 104, 111, 112};
  logic        he[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int          t0;
  int          hs_cnt;
  int          de_cnt;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    mode = 3'd1;
    solid_rgb = 24'h123456;
    repeat (3) step();
    check_val("rst_pos", {vid.x, vid.y}, 24'h0);
    check_val("rst_de", vid.de, 1'b0);
    check_val("rst_hs", vid.hsync, 1'b0);
    check_val("rst_vs", vid.vsync, 1'b1);
    check_val("rst_rgb", rgb, 24'h0);
    check_val("rst_fs", vid.frame_start, 1'b0);
    check_val("rst_mode", mode_active, 3'd0);

    // frame 0: colour bars
    rst = 1'b0;
    en = 1'b1;
    step();
    t0 = n_steps;
    check_val("f0_pos", {vid.x, vid.y}, 24'h0);
    check_val("f0_fs", vid.frame_start, 1'b1);
    check_val("f0_de", vid.de, 1'b1);
    check_val("f0_rgb", rgb, 24'hffffff);
    check_val("f0_mode", mode_active, 3'd1);
    step();
    check_val("fs_pulse", vid.frame_start, 1'b0);
    for (int i = 0; i < 6; i++) begin
      goto(bx[i], 0);
      check_val($sformatf("bar_x%0d", bx[i]), rgb, be[i]);
    end
    check_val("de_x99", vid.de, 1'b1);
    goto(100, 0);
    check_val("de_x100", vid.de, 1'b0);
    check_val("rgb_x100", rgb, 24'h0);
    for (int i = 0; i < 4; i++) begin
      goto(hx[i], 0);
      check_val($sformatf("hs_x%0d", hx[i]), vid.hsync, he[i]);
    end
    goto(0, 1);
    hs_cnt = 0;
    de_cnt = 0;
    for (int i = 0; i < H_TOTAL; i++) begin
      hs_cnt += int'(vid.hsync);
      de_cnt += int'(vid.de);
      step();
    end
    check_val("hs_width", hs_cnt, 8);
    check_val("de_width", de_cnt, 100);
    goto(0, 3);
    mode = 3'd0;
    goto(12, 3);
    check_val("midframe_rgb", rgb, 24'hffff00);
    check_val("midframe_mode", mode_active, 3'd1);
    goto(0, 6);
    check_val("de_y6", vid.de, 1'b0);
    check_val("vs_y6", vid.vsync, 1'b1);
    goto(119, 6);
    check_val("vs_y6_end", vid.vsync, 1'b1);
    goto(0, 7);
    check_val("vs_y7", vid.vsync, 1'b0);
    goto(119, 8);
    check_val("vs_y8_end", vid.vsync, 1'b0);
    goto(0, 9);
    check_val("vs_y9", vid.vsync, 1'b1);

    // frame 1: grid, switch to solid at line 3
    goto(0, 0);
    check_val("frame_period", n_steps - t0, 1200);
    check_val("f1_fs", vid.frame_start, 1'b1);
    check_val("f1_mode", mode_active, 3'd0);
    check_val("grid_0_0", rgb, 24'hffffff);
    goto(90, 0);
    check_val("grid_90_0", rgb, 24'h680000);
    goto(5, 1);
    check_val("grid_5_1", rgb, 24'h000001);
    goto(0, 3);
    mode = 3'd2;
    goto(3, 3);
    check_val("grid_3_3", rgb, 24'hffffff);
    goto(24, 3);
    check_val("grid_24_3", rgb, 24'h600003);
    goto(60, 5);
    check_val("grid_60_5", rgb, 24'hf00005);
    check_val("f1_mode_hold", mode_active, 3'd0);

    // frame 2: solid, with enable pauses
    goto(0, 0);
    check_val("f2_mode", mode_active, 3'd2);
    check_val("solid_0_0", rgb, 24'h123456);
    goto(40, 2);
    check_val("solid_40_2", rgb, 24'h123456);
    en = 1'b0;
    repeat (50) step();
    check_val("pause_pos", {vid.x, vid.y}, {12'd40, 12'd2});
    check_val("pause_de", vid.de, 1'b0);
    check_val("pause_rgb", rgb, 24'h0);
    check_val("pause_hs", vid.hsync, 1'b0);
    check_val("pause_vs", vid.vsync, 1'b1);
    check_val("pause_fs", vid.frame_start, 1'b0);
    en = 1'b1;
    step();
    check_val("resume_pos", {vid.x, vid.y}, {12'd41, 12'd2});
    check_val("resume_rgb", rgb, 24'h123456);
    check_val("resume_de", vid.de, 1'b1);
    goto(106, 3);
    en = 1'b0;
    repeat (10) step();
    check_val("pause_hs_held", vid.hsync, 1'b1);
    en = 1'b1;
    goto(99, 5);
    check_val("solid_99_5", rgb, 24'h123456);
    goto(100, 5);
    check_val("solid_100_5", rgb, 24'h0);
    mode = 3'd3;

    // frame 3: ramp
    goto(0, 0);
    check_val("ramp_0", rgb, grey(0));
    goto(45, 1);
    check_val("ramp_45", rgb, grey(45));
    goto(99, 2);
    check_val("ramp_99", rgb, grey(99));
    goto(0, 3);
    mode = 3'd4;

    // frame 4: checker
    goto(0, 0);
    check_val("chk_0_0", rgb, chk(0, 0));
    goto(4, 0);
    check_val("chk_4_0", rgb, chk(4, 0));
    goto(0, 4);
    check_val("chk_0_4", rgb, chk(0, 4));
    goto(4, 4);
    check_val("chk_4_4", rgb, chk(4, 4));
    goto(0, 5);
    mode = 3'd3;
    goto(50, 5);
    check_val("chk_50_5", rgb, chk(50, 5));

    // frame 5: ramp again, then reset mid-frame
    goto(0, 0);
    check_val("f5_ramp_0", rgb, grey(0));
`ifdef VPG_SCROLL_EN
    check_val("f5_frame_cnt", frame_cnt, cur_frame);
`endif
    goto(30, 2);
    rst = 1'b1;
    #1;
    check_val("arst_pos", {vid.x, vid.y}, 24'h0);
    check_val("arst_de", vid.de, 1'b0);
    check_val("arst_rgb", rgb, 24'h0);
    check_val("arst_mode", mode_active, 3'd0);
    check_val("arst_vs", vid.vsync, 1'b1);
    repeat (3) step();
    mc_h = 0;
    mc_v = 0;
    n_starts = 0;
    rst = 1'b0;
    step();
    check_val("post_rst_pos", {vid.x, vid.y}, 24'h0);
    check_val("post_rst_fs", vid.frame_start, 1'b1);
    check_val("post_rst_de", vid.de, 1'b1);
    check_val("post_rst_mode", mode_active, 3'd3);
    check_val("post_rst_rgb", rgb, grey(0));
`ifdef VPG_SCROLL_EN
    check_val("post_rst_frame_cnt", frame_cnt, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised video timing and test-pattern source for the HDMI/DVI output path.
- Generates x/y position, DE, hsync, vsync and RGB for any CEA/VESA-style timing.
- Selects at runtime between several test patterns; pattern changes take effect only at frame boundaries.
- Feeds the existing per-channel TMDS encoders directly (DE→VDE, {vsync,hsync}→blue CD).

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 1, hsync asserted level (1 = high)
- VS_POL, 1, vsync asserted level
- COLOR_W, 8, bits per colour channel (4..12)
- CNT_W, 12, x/y counter width; must hold H_TOTAL-1 and V_TOTAL-1
- CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels

Ports:
- pixclk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- en  in  1  counter advance enable
- mode  in  3  requested pattern, sampled at frame start
- solid_rgb  in  3*COLOR_W  {R,G,B} for solid mode
- x  out  CNT_W  horizontal position of the current output pixel
- y  out  CNT_W  vertical position of the current output pixel
- de  out  1  active-video flag
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red/green/blue  out  COLOR_W each  pixel colour
- frame_start  out  1  one-cycle pulse, aligned with output pixel (0,0)
- mode_active  out  3  pattern currently displayed

Behaviour:
- Interface: one clock, pixclk. Reset is rst, asynchronous and active-high.
- Reset values: internal h/v counters 0, x=y=0, de=0, hsync=~HS_POL, vsync=~VS_POL, RGB=0, frame_start=0, mode_active=0.
- Counters: h counts 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP. On h wrap, v advances 0..V_TOTAL-1 and wraps to 0. Both advance only while en=1.
- Registered outputs, 1-cycle latency from counter state; all outputs are mutually aligned.
- de = (h<H_ACTIVE)&&(v<V_ACTIVE).
- hsync asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted for whole lines when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync changes only at h=0.
- en=0: counters hold; de, RGB and frame_start forced 0; syncs hold their last value.
- Mode latch: mode is sampled into mode_active only when the counters are at (0,0) and en=1. A change mid-frame is invisible until the next frame.
- Patterns (RGB=0 whenever de=0):
  - 0 grid: legacy 8-bit diagonal/grid pattern, MSB-aligned to COLOR_W (truncate or zero-pad LSBs).
    - W = x[7:0]==y[7:0]
    - A = x[7:5]==2 && y[7:5]==2
    - R = ({x[5:0] masked by y[4:3]==~x[4:3], 2'b00} | W) & ~A
    - G = (x[7:0] & {8{y[6]}} | W) & ~A
    - B = y[7:0] | W | A
  - 1 bars: 8 vertical bars in order white, yellow, cyan, green, magenta, red, blue, black, full-scale.
    - Bar width BW = H_ACTIVE/8 (integer).
    - Bar index comes from a sequential sub-counter reset at h=0; no divider.
    - Index saturates at 7, so the last bar absorbs the remainder.
  - 2 solid: solid_rgb, sampled every pixel.
  - 3 ramp: grey level = x[COLOR_W-1:0], wrapping.
  - 4 checker: white if x[CHK_LOG2]^y[CHK_LOG2], else black.
  - 5–7: black.
- frame_start is high only on the output cycle carrying pixel (0,0) with en=1.
- Reset asserted mid-frame: all state returns to reset values immediately. After deassertion, output starts at pixel (0,0) on the first enabled cycle.

Optional Feature:
- Macro VPG_SCROLL_EN.
- Defined:
  - Adds internal 16-bit frame counter, incremented at each frame_start and cleared by rst.
  - Bars, ramp and checker use x' = (x + frame_cnt) mod 2^CNT_W, so patterns scroll one pixel per frame.
  - Adds output port frame_cnt (16).
- Undefined: no frame counter and no frame_cnt port; patterns are static.

Decomposition:
- Package vpg_pkg holds:
  - mode enum (MODE_GRID, MODE_BARS, MODE_SOLID, MODE_RAMP, MODE_CHECKER)
  - 8-entry 3-bit bar colour table
  - function computing totals from the porch parameters
- Sub-module vpg_timing: h/v counters, sync/DE generation, frame_start.
- Parent video_pattern_gen: mode latch, bar sub-counter, pattern mux, output registers.

Test Plan:
- Defaults, en=1 after reset:
  - first de=1 one cycle after release with x=0, y=0
  - line period 800 cycles; de high 640 cycles per active line
  - hsync high for 96 cycles starting at output x=656
  - frame_start period 420000 cycles; vsync high 1600 cycles starting at y=490
- mode=1:
  - x=0..79 gives RGB FF/FF/FF
  - x=80 gives FF/FF/00
  - x=560..639 gives 00/00/00
  - H_ACTIVE=100 override: bar 7 spans x=84..99
- mode 0→2 (solid_rgb=12/34/56) switched at line 100:
  - rest of frame stays grid
  - from the next frame_start, mode_active=2 and every active pixel is 12/34/56
- en=0 for 50 cycles mid-line: x/y frozen, de=0, RGB=0, syncs unchanged; resume continues from the next x.
- rst pulsed at (x=300, y=200): outputs return to reset values asynchronously; first pixel after release is (0,0) with frame_start=1.
- VPG_SCROLL_EN defined, mode=3: frame 0 x=0 grey 00; frame 5 x=0 grey 05; frame_cnt=5.
